// File: rtl/mem_clint_mh_pkg.sv
// Shared definitions for the multi-hart CLINT: request/response codes, register offsets, sizes.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package mem_clint_mh_pkg;

    localparam logic REQ_READ  = 1'b0;
    localparam logic REQ_WRITE = 1'b1;

    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam logic [1:0] RESP_ERR  = 2'b10;

    localparam logic [63:0] CLINT_MSIP_OFF     = 64'h0000;
    localparam logic [63:0] CLINT_MTIMECMP_OFF = 64'h4000;
    localparam logic [63:0] CLINT_MTIME_OFF    = 64'hBFF8;

    localparam logic [1:0] SIZE_BYTE  = 2'd0;
    localparam logic [1:0] SIZE_HALF  = 2'd1;
    localparam logic [1:0] SIZE_WORD  = 2'd2;
    localparam logic [1:0] SIZE_DWORD = 2'd3;

    typedef enum logic {ST_IDLE, ST_RESP} state_t;

    typedef enum logic [1:0] {TGT_NONE, TGT_MSIP, TGT_MTIMECMP, TGT_MTIME} tgt_t;

    typedef struct packed {
        logic [63:0] dat;
        logic [1:0]  resp;
        logic        wr;
    } rsp_t;

    // Lane mask of an access starting at byte 0.
    function automatic logic [7:0] size_lanes(input logic [1:0] size);
        case (size)
            SIZE_BYTE: return 8'h01;
            SIZE_HALF: return 8'h03;
            SIZE_WORD: return 8'h0F;
            default:   return 8'hFF;
        endcase
    endfunction

    // Address bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] align_mask(input logic [1:0] size);
        case (size)
            SIZE_BYTE: return 3'b000;
            SIZE_HALF: return 3'b001;
            SIZE_WORD: return 3'b011;
            default:   return 3'b111;
        endcase
    endfunction

endpackage

// File: rtl/mem_clint_mh_byte_merge.sv
// Merges LSB-aligned write data into a 64-bit register at a byte offset; returns lane mask.
// Latency: combinational.
// Backpressure: none.
module clint_byte_merge
    import mem_clint_mh_pkg::*;
(
    input  logic [63:0] old_val,
    input  logic [63:0] wr_dat,
    input  logic [2:0]  ofs,
    input  logic [1:0]  size,
    output logic [63:0] merged,
    output logic [7:0]  lane_mask
);

    logic [63:0] shifted;

    always_comb begin
        lane_mask = size_lanes(size) << ofs;
        shifted   = wr_dat << {ofs, 3'b000};
        merged    = old_val;
        for (int i = 0; i < 8; i++) begin
            if (lane_mask[i]) merged[8*i +: 8] = shifted[8*i +: 8];
        end
    end

endmodule

// File: rtl/mem_clint_mh.sv
// Multi-hart CLINT: shared prescaled mtime, per-hart mtimecmp/msip, registered IRQ lines.
// Latency: response strobe one cycle after acceptance; one access per two cycles.
// Backpressure: valid is held by the requester; requests are ignored while a response is out.
module mem_clint_mh
    import mem_clint_mh_pkg::*;
#(
    parameter int          HART_NUM  = 2,
    parameter int          PRESCALE  = 16,
    parameter logic [63:0] BASE_ADDR = 64'h0200_0000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                mem_clint_clint_valid_i,
    input  logic                mem_clint_clint_req_i,
    input  logic [63:0]         mem_clint_clint_addr_i,
    input  logic [1:0]          mem_clint_clint_size_i,
    input  logic [63:0]         mem_clint_clint_data_write_i,
    output logic                mem_clint_clint_ready_o,
    output logic [63:0]         mem_clint_clint_data_read_o,
    output logic [1:0]          mem_clint_clint_resp_o,
    output logic [HART_NUM-1:0] mem_clint_clint_mtip_o,
    output logic [HART_NUM-1:0] mem_clint_clint_msip_o,
    output logic                mem_clint_clint_update_o
);

    localparam int HW = (HART_NUM > 1) ? $clog2(HART_NUM) : 1;
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    state_t          state_q, state_d;
    rsp_t            rsp_q;
    logic [63:0]     mtime_q;
    logic [PW-1:0]   pre_q;
    logic [63:0]     mtimecmp [HART_NUM];
    logic [HART_NUM-1:0] msip_bits;
    logic [HART_NUM-1:0] mtip_bits;

    logic [63:0]     off, idx, old_val, merged, byte_en, rd_dat;
    logic [7:0]      lane_mask;
    logic [2:0]      ofs;
    logic [HW-1:0]   hart;
    tgt_t            tgt;
    logic            misalign, err, acc_vld, wr_en, tick;

    assign acc_vld = (state_q == ST_IDLE) && mem_clint_clint_valid_i;
    assign wr_en   = acc_vld && (mem_clint_clint_req_i == REQ_WRITE) && !err;
    assign tick    = (pre_q == PW'(PRESCALE - 1));

    // Address decode: msip uses its containing word, the 64-bit registers their dword.
    always_comb begin
        off = mem_clint_clint_addr_i - BASE_ADDR;
        tgt = TGT_NONE;
        idx = '0;
        if (off < CLINT_MTIMECMP_OFF) begin
            tgt = TGT_MSIP;
            idx = (off - CLINT_MSIP_OFF) >> 2;
        end else if (off[63:3] == CLINT_MTIME_OFF[63:3]) begin
            tgt = TGT_MTIME;
        end else if (off < CLINT_MTIME_OFF) begin
            tgt = TGT_MTIMECMP;
            idx = (off - CLINT_MTIMECMP_OFF) >> 3;
        end
        hart     = idx[HW-1:0];
        misalign = |(mem_clint_clint_addr_i[2:0] & align_mask(mem_clint_clint_size_i));
        err      = (tgt == TGT_NONE) || (idx >= 64'(HART_NUM)) || misalign ||
                   ((tgt == TGT_MSIP) && (mem_clint_clint_size_i == SIZE_DWORD));
        old_val  = '0;
        ofs      = mem_clint_clint_addr_i[2:0];
        case (tgt)
            TGT_MSIP: begin
                old_val = {63'b0, msip_bits[hart]};
                ofs     = {1'b0, mem_clint_clint_addr_i[1:0]};
            end
            TGT_MTIMECMP: old_val = mtimecmp[hart];
            TGT_MTIME:    old_val = mtime_q;
            default:      old_val = '0;
        endcase
    end

    clint_byte_merge u_merge (
        .old_val   (old_val),
        .wr_dat    (mem_clint_clint_data_write_i),
        .ofs       (ofs),
        .size      (mem_clint_clint_size_i),
        .merged    (merged),
        .lane_mask (lane_mask)
    );

    always_comb begin
        byte_en = '0;
        for (int i = 0; i < 8; i++) byte_en[8*i +: 8] = {8{lane_mask[i]}};
        rd_dat = (old_val & byte_en) >> {ofs, 3'b000};
    end

    // A write to mtime on a tick edge takes precedence; that tick is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q   <= '0;
            mtime_q <= '0;
        end else begin
            pre_q <= tick ? '0 : pre_q + PW'(1);
            if (wr_en && (tgt == TGT_MTIME)) mtime_q <= merged;
            else if (tick)                   mtime_q <= mtime_q + 64'd1;
        end
    end

    for (genvar h = 0; h < HART_NUM; h++) begin : g_hart
        logic [63:0] cmp_q;
        logic        msip_q;
        logic        mtip_q;
        logic        sel;

        assign sel = (hart == HW'(h));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cmp_q  <= '1;
                msip_q <= 1'b0;
                mtip_q <= 1'b0;
            end else begin
                if (wr_en && sel && (tgt == TGT_MTIMECMP)) cmp_q  <= merged;
                if (wr_en && sel && (tgt == TGT_MSIP))     msip_q <= merged[0];
                mtip_q <= (mtime_q >= cmp_q);
            end
        end

        assign mtimecmp[h]  = cmp_q;
        assign msip_bits[h] = msip_q;
        assign mtip_bits[h] = mtip_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_q <= '0;
        end else if (acc_vld) begin
            rsp_q.dat  <= (err || (mem_clint_clint_req_i == REQ_WRITE)) ? '0 : rd_dat;
            rsp_q.resp <= err ? RESP_ERR : RESP_OKAY;
            rsp_q.wr   <= (mem_clint_clint_req_i == REQ_WRITE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (mem_clint_clint_valid_i) state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_clint_clint_ready_o     = 1'b0;
        mem_clint_clint_data_read_o = '0;
        mem_clint_clint_resp_o      = RESP_OKAY;
        mem_clint_clint_update_o    = 1'b0;
        if (state_q == ST_RESP) begin
            mem_clint_clint_ready_o     = 1'b1;
            mem_clint_clint_data_read_o = rsp_q.dat;
            mem_clint_clint_resp_o      = rsp_q.resp;
            mem_clint_clint_update_o    = rsp_q.wr;
        end
    end

    assign mem_clint_clint_mtip_o = mtip_bits;
    assign mem_clint_clint_msip_o = msip_bits;

endmodule

// File: tb/tb_mem_clint_mh.sv
// Bench for mem_clint_mh: directed steps plus random accesses against a time-based reference model.
module tb_mem_clint_mh;

    localparam int          HN   = 2;
    localparam int          PRE  = 4;
    localparam logic [63:0] BASE = 64'h0200_0000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          valid;
    logic          req;
    logic [63:0]   addr;
    logic [1:0]    size;
    logic [63:0]   wdata;
    logic          ready;
    logic [63:0]   rdata;
    logic [1:0]    resp;
    logic [HN-1:0] mtip;
    logic [HN-1:0] msip;
    logic          upd;

    mem_clint_mh #(.HART_NUM(HN), .PRESCALE(PRE), .BASE_ADDR(BASE)) dut (
        .clk                          (clk),
        .rst_n                        (rst_n),
        .mem_clint_clint_valid_i      (valid),
        .mem_clint_clint_req_i        (req),
        .mem_clint_clint_addr_i       (addr),
        .mem_clint_clint_size_i       (size),
        .mem_clint_clint_data_write_i (wdata),
        .mem_clint_clint_ready_o      (ready),
        .mem_clint_clint_data_read_o  (rdata),
        .mem_clint_clint_resp_o       (resp),
        .mem_clint_clint_mtip_o       (mtip),
        .mem_clint_clint_msip_o       (msip),
        .mem_clint_clint_update_o     (upd)
    );

    always #5 clk = ~clk;

    // Edges since reset release; mtime ticks on every edge k with k % PRE == 0.
    int cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Model: mtime after edge j = base value + ticks elapsed since the edge it was written.
    logic [63:0] t_val, t_pval;
    int          t_edge, t_pedge;
    logic [63:0] c_val [HN];
    logic [63:0] c_pval[HN];
    int          c_edge[HN];
    logic        msip_m[HN];

    task automatic model_reset();
        t_val = '0; t_pval = '0; t_edge = 0; t_pedge = 0;
        for (int h = 0; h < HN; h++) begin
            c_val[h] = '1; c_pval[h] = '1; c_edge[h] = 0; msip_m[h] = 1'b0;
        end
    endtask

    function automatic logic [63:0] mt_at(input int j);
        if (j >= t_edge) return t_val + 64'((j / PRE) - (t_edge / PRE));
        return t_pval + 64'((j / PRE) - (t_pedge / PRE));
    endfunction

    function automatic logic [63:0] cmp_at(input int h, input int j);
        return (j >= c_edge[h]) ? c_val[h] : c_pval[h];
    endfunction

    function automatic logic [HN-1:0] mtip_exp(input int j);
        logic [HN-1:0] r;
        for (int h = 0; h < HN; h++) r[h] = (mt_at(j) >= cmp_at(h, j));
        return r;
    endfunction

    function automatic logic [HN-1:0] msip_exp();
        logic [HN-1:0] r;
        for (int h = 0; h < HN; h++) r[h] = msip_m[h];
        return r;
    endfunction

    // kind: 0 unmapped, 1 msip, 2 mtimecmp, 3 mtime
    function automatic void decode(input logic [63:0] a, input logic [1:0] sz,
                                   output int kind, output int h, output bit err);
        logic [63:0] off;
        off  = a - BASE;
        kind = 0;
        h    = 0;
        if (off < 64'h4000) begin
            kind = 1; h = int'(off / 4);
        end else if (off >= 64'hBFF8 && off < 64'hC000) begin
            kind = 3;
        end else if (off < 64'hBFF8) begin
            kind = 2; h = int'((off - 64'h4000) / 8);
        end
        err = (kind == 0) || (kind != 3 && h >= HN) ||
              ((a % (64'd1 << sz)) != 0) || (kind == 1 && sz == 2'd3);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Entered and left at a falling edge with the DUT idle.
    task automatic acc(input bit wr, input logic [63:0] a, input logic [1:0] sz,
                       input logic [63:0] wd, output logic [63:0] rd, output logic [1:0] rs);
        int kind, h, w, nb, ob;
        bit err;
        logic [63:0] cur, exp_rd, nv;
        decode(a, sz, kind, h, err);
        valid = 1'b1; req = wr; addr = a; size = sz; wdata = wd;
        @(posedge clk); #1;
        w = cyc;
        // Junk held through the response cycle must be ignored.
        req = 1'b1; addr = BASE; size = 2'd2; wdata = {$urandom, $urandom};
        nb = 1 << sz;
        cur = '0; ob = 0;
        if (!err) begin
            case (kind)
                1: begin cur = {63'b0, msip_m[h]}; ob = int'(a[1:0]); end
                2: begin cur = cmp_at(h, w - 1);   ob = int'(a[2:0]); end
                default: begin cur = mt_at(w - 1); ob = int'(a[2:0]); end
            endcase
        end
        exp_rd = '0;
        if (!err && !wr)
            for (int i = 0; i < nb; i++) exp_rd[8*i +: 8] = cur[8*(ob+i) +: 8];
        if (!err && wr) begin
            nv = cur;
            for (int i = 0; i < nb; i++) nv[8*(ob+i) +: 8] = wd[8*i +: 8];
            case (kind)
                1: msip_m[h] = nv[0];
                2: begin c_pval[h] = c_val[h]; c_val[h] = nv; c_edge[h] = w; end
                default: begin t_pval = t_val; t_pedge = t_edge; t_val = nv; t_edge = w; end
            endcase
        end
        @(negedge clk);
        chk("ready", ready, 1);
        chk("resp", resp, err ? 2'b10 : 2'b00);
        chk("rdata", rdata, exp_rd);
        chk("update", upd, wr);
        chk("mtip_pre", mtip, mtip_exp(w - 1));
        rd = rdata;
        rs = resp;
        @(negedge clk);
        valid = 1'b0;
        chk("ready_strobe", ready, 0);
        chk("msip", msip, msip_exp());
        chk("mtip", mtip, mtip_exp(w));
    endtask

    initial begin
        logic [63:0] rd;
        logic [1:0]  rs;
        bit          wr;
        logic [1:0]  sz;
        logic [63:0] a;
        int          k;

        rst_n = 1'b0; valid = 1'b0; req = 1'b0; addr = '0; size = '0; wdata = '0;
        model_reset();
        #23;
        chk("rst_ready", ready, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_resp", resp, 0);
        chk("rst_update", upd, 0);
        chk("rst_mtip", mtip, 0);
        chk("rst_msip", msip, 0);
        @(negedge clk); rst_n = 1'b1;

        acc(1'b0, BASE + 64'h4000, 2'd3, '0, rd, rs);
        chk("rst_mtimecmp0", rd, 64'hFFFF_FFFF_FFFF_FFFF);

        // Prescaler from a fresh reset
        @(negedge clk); rst_n = 1'b0;
        #2; rst_n = 1'b1;
        model_reset();
        repeat (40) @(posedge clk);
        @(negedge clk);
        acc(1'b0, BASE + 64'hBFF8, 2'd3, '0, rd, rs);
        chk("mtime_40cyc", rd, 64'd10);

        // Per-hart timer interrupt
        acc(1'b1, BASE + 64'h4008, 2'd3, 64'd5, rd, rs);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            k = cyc;
            chk("mtip_track", mtip, mtip_exp(k - 1));
        end
        chk("mtip_h1_set", mtip, 2'b10);
        acc(1'b1, BASE + 64'h4008, 2'd3, '1, rd, rs);
        chk("mtip_h1_clr", mtip[1], 0);

        // Byte-lane write and sub-word reads
        acc(1'b1, BASE + 64'h4000, 2'd3, 64'd0, rd, rs);
        acc(1'b1, BASE + 64'h4003, 2'd0, 64'hAB, rd, rs);
        acc(1'b0, BASE + 64'h4000, 2'd3, '0, rd, rs);
        chk("byte_lane_dword", rd, 64'h0000_0000_AB00_0000);
        acc(1'b0, BASE + 64'h4002, 2'd1, '0, rd, rs);
        chk("byte_lane_half", rd, 64'hAB00);

        // Error responses
        acc(1'b1, BASE + 64'h0001, 2'd1, 64'hFFFF, rd, rs);
        chk("err_misalign", rs, 2'b10);
        chk("err_no_change", msip, 0);
        acc(1'b0, BASE + 64'h0008, 2'd2, '0, rd, rs);
        chk("err_msip_hart", rs, 2'b10);
        acc(1'b0, BASE + 64'h0000, 2'd3, '0, rd, rs);
        chk("err_msip_dword", rs, 2'b10);
        acc(1'b1, BASE - 64'd8, 2'd3, '1, rd, rs);
        chk("err_unmapped", rs, 2'b10);

        // msip write with only bit 0 stored
        acc(1'b1, BASE, 2'd2, 64'hFFFF_FFFF, rd, rs);
        chk("msip0_out", msip[0], 1);
        acc(1'b0, BASE, 2'd2, '0, rd, rs);
        chk("msip0_read", rd, 64'd1);

        // Random accesses
        for (int n = 0; n < 80; n++) begin
            wr = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 6))
                0, 1: a = BASE + 64'(4 * $urandom_range(0, 2)) + 64'(($urandom_range(0, 3) >> sz) << sz);
                2, 3: a = BASE + 64'h4000 + 64'(8 * $urandom_range(0, 2)) + 64'(($urandom_range(0, 7) >> sz) << sz);
                4:    a = BASE + 64'hBFF8 + 64'(($urandom_range(0, 7) >> sz) << sz);
                5:    a = ($urandom_range(0, 1) == 1) ? BASE + 64'hC008 : BASE - 64'd8;
                default: begin
                    sz = 2'($urandom_range(1, 3));
                    a  = BASE + 64'h4001;
                end
            endcase
            acc(wr, a, sz, {$urandom, $urandom}, rd, rs);
        end

        // mtime write on a tick edge wins over the tick
        acc(1'b1, BASE + 64'hBFF8, 2'd3, 64'd0, rd, rs);
        while (cyc % PRE != PRE - 1) @(negedge clk);
        acc(1'b1, BASE + 64'hBFF8, 2'd3, 64'd100, rd, rs);
        acc(1'b0, BASE + 64'hBFF8, 2'd3, '0, rd, rs);
        chk("collision_mtime", rd, 64'd100);

        // Reset while a response is pending
        valid = 1'b1; req = 1'b0; addr = BASE + 64'hBFF8; size = 2'd3;
        @(posedge clk); #1;
        valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_ready", ready, 0);
        chk("midrst_update", upd, 0);
        chk("midrst_mtip", mtip, 0);
        chk("midrst_msip", msip, 0);
        rst_n = 1'b1;
        model_reset();
        acc(1'b0, BASE + 64'hBFF8, 2'd3, '0, rd, rs);
        chk("midrst_mtime", rd, 64'd0);
        acc(1'b0, BASE + 64'h4008, 2'd3, '0, rd, rs);
        chk("midrst_mtimecmp1", rd, 64'hFFFF_FFFF_FFFF_FFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_clint_mh.md
# mem_clint_mh

Multi-hart, parametrised core-local interruptor on the memory-side peripheral port. It holds one shared `mtime` with a programmable prescaler, plus one `mtimecmp` and one `msip` per hart. It accepts byte, half, word and dword accesses through a registered valid/ready handshake, and drives per-hart timer and software interrupt lines to the CSR units. It replaces the single-hart CLINT, which had fixed 64-bit accesses and a combinational response.

## Interface
- `HART_NUM`, 2: harts served, 1..8.
- `PRESCALE`, 16: clock cycles per `mtime` increment, at least 1.
- `BASE_ADDR`, 64'h0200_0000: region base address.
- `clk` in 1: the only clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `mem_clint_clint_valid_i` in 1: request valid; held until `ready_o`.
- `mem_clint_clint_req_i` in 1: request type, `REQ_READ` or `REQ_WRITE`.
- `mem_clint_clint_addr_i` in 64: byte address.
- `mem_clint_clint_size_i` in 2: 0 = byte, 1 = half, 2 = word, 3 = dword.
- `mem_clint_clint_data_write_i` in 64: write data, LSB-aligned.
- `mem_clint_clint_ready_o` out 1: one-cycle response strobe.
- `mem_clint_clint_data_read_o` out 64: read data, LSB-aligned and zero-extended; valid with `ready_o`.
- `mem_clint_clint_resp_o` out 2: 2'b00 OKAY, 2'b10 error; valid with `ready_o`.
- `mem_clint_clint_mtip_o` out HART_NUM: per-hart timer interrupt.
- `mem_clint_clint_msip_o` out HART_NUM: per-hart software interrupt.
- `mem_clint_clint_update_o` out 1: one-cycle pulse after every accepted write.

## Operation
- Register map, where off = addr − BASE_ADDR:
  - `msip[h]` at off 4h; 32-bit; only bit 0 is stored, other bits read as 0.
  - `mtimecmp[h]` at off 0x4000 + 8h.
  - `mtime` at off 0xBFF8.
- Access decode:
  - The register is chosen by the access's containing aligned word (msip) or dword (mtimecmp, mtime).
  - Byte lanes addressed = `addr[2:0]` .. `addr[2:0] + 2^size − 1`.
- Write:
  - Only the addressed lanes are updated.
  - Source bytes come from `data_write_i[8·2^size−1:0]`.
- Read: the addressed lanes are right-shifted to bit 0; upper bits are zero.
- Error response (`resp` 2'b10, no state change, read data 0) when any of these hold:
  - the address is unmapped;
  - the hart index is ≥ HART_NUM;
  - the access is misaligned (`addr` not a multiple of 2^size);
  - the access is a dword to msip.
- Prescaler:
  - Counter `pre` counts 0..PRESCALE−1 and wraps.
  - `mtime` increments when `pre == PRESCALE−1`.
  - `mtime` wraps from 2^64−1 to 0.
  - `pre` is not affected by writes.
- Priority: when a write to `mtime` and a tick occur in the same cycle, the write wins and that tick is lost.
- Interrupts, registered:
  - `mtip_o[h] <= (mtime >= mtimecmp[h])` every cycle; the comparison is unsigned 64-bit.
  - `msip_o[h]` is the `msip[h]` bit directly.
- Handshake state machine, states IDLE and RESP:
  - IDLE → RESP when `valid_i` is high. The request is sampled and executed at this edge.
  - RESP → IDLE unconditionally. `ready_o`, `data_read_o` and `resp_o` are driven from registers in RESP.
  - `valid_i` is ignored while in RESP.
  - A new request can be accepted in the cycle after `ready_o`.
- `update_o` is high in RESP when the request was a write, including errored writes.

## Timing
- Reset values:
  - `ready_o` = 0, `data_read_o` = 0, `resp_o` = 0, `update_o` = 0, `msip_o` = 0, `mtip_o` = 0.
  - `mtime` = 0, `pre` = 0.
  - `mtimecmp[h]` = all ones, so no interrupt is raised after reset.
- Latency:
  - Response: `ready_o` one cycle after the accepting edge.
  - Throughput: one access per 2 cycles.
  - A write to `mtime` or `mtimecmp` shows on `mtip_o` two edges after acceptance.
- A read returns the register value as of the accepting edge, before any tick that occurs at that same edge.
- Reset mid-transaction: the state machine returns to IDLE immediately, the pending response is dropped, and all registers take their reset values.

## Structure
- The shared defines file holds:
  - `REQ_READ` / `REQ_WRITE`;
  - the response codes;
  - `CLINT_MSIP_OFF`, `CLINT_MTIMECMP_OFF`, `CLINT_MTIME_OFF`;
  - the size encodings.
- Sub-module `clint_byte_merge` (combinational): takes old value, write data, offset and size, and returns the merged 64-bit value plus a lane mask. It is instantiated once and used for all registers.
- The per-hart `mtimecmp`/`msip` registers are built with a generate loop.

## Test plan
- Reset → `mtip_o` = 0, `msip_o` = 0, `mtimecmp[0]` reads 64'hFFFF_FFFF_FFFF_FFFF, `ready_o` = 0.
- Prescaler: PRESCALE = 4, 40 idle cycles → `mtime` reads 10.
- Per-hart timer interrupt:
  - Write `mtimecmp[1]` = 5 (dword) → `mtip_o` = 2'b10 once `mtime` ≥ 5.
  - Then rewrite `mtimecmp[1]` to all ones → `mtip_o[1]` clears two edges after acceptance.
- Byte-lane write: byte 0xAB written to off 0x4003 with `mtimecmp[0]` = 0 → `mtimecmp[0]` = 0x00000000AB000000; half read at 0x4002 returns 0xAB00.
- Error responses:
  - Half access at off 0x0001 → `resp` 2'b10, no change.
  - Access to `msip[HART_NUM]` → `resp` 2'b10.
  - Write to off 0x0 with data 0xFFFFFFFF → `msip_o[0]` = 1, reads back as 1.
- Collision and reset:
  - Write `mtime` = 100 on a tick edge → `mtime` reads 100, not 101.
  - Assert `rst_n` in the RESP state → no `ready_o`, `mtime` = 0.
